q_ring_sequencer: RTL and testbench
===================================

# q_ring_sequencer

Synchronous controller that sequences a ring of Q-flop pipeline stages: it runs the ring's reset/start initialisation, releases the ring, counts token passes seen at the ring's observation point, and returns the ring to reset when the requested count is reached or the ring stalls. It sits between the clocked test/control logic and the self-timed `q_stage` ring, and directly drives the ring's shared `start` and `rst` nets.

## Interface
- `NSTAGES`, 5, number of `q_stage` instances whose `f` outputs are monitored
- `CNT_W`, 16, width of the run-length and event counters
- `RESET_CYCLES`, 2, cycles with ring start=1 and rst=1 (minimum 1)
- `ARM_CYCLES`, 2, cycles with ring start=0 and rst=1 (minimum 1)
- `TIMEOUT`, 255, idle cycles in RUN before a stall is declared (minimum 1)

- `clk` in 1: single clock
- `rst` in 1: synchronous reset, active-high
- `run_req` in 1: request a run; sampled only in IDLE
- `run_len` in CNT_W: number of lap events to count; captured when `run_req` is accepted
- `abort` in 1: cancel the current run
- `lap_in` in 1: asynchronous two-phase lap signal from the ring, taken from stage 1 `po`
- `f_in` in NSTAGES: asynchronous stage `f` flags
- `ring_start` out 1: drives the `start` net of every stage
- `ring_rst` out 1: drives the `rst` net of every stage
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at run completion, whether normal or timeout
- `timeout_err` out 1: set when a run ends by stall; cleared on the next accepted `run_req`
- `lap_count` out CNT_W: events counted in the current or most recent run
- `occupancy` out clog2(NSTAGES+1): number of synchronised `f_in` bits that are high

## Operation
- All outputs are registered. Reset values:
  - `ring_rst`=1, `ring_start`=0
  - `busy`=0, `done`=0, `timeout_err`=0
  - `lap_count`=0, `occupancy`=0
  - all synchroniser flops=0
  - state=IDLE
- `lap_in` and each `f_in` bit pass through a 2-flop synchroniser. `occupancy` is the popcount of the synchronised `f_in`, registered once.
- A lap event is any transition of synchronised `lap_in` (two-phase signalling, so both rising and falling edges count). The edge-detect register `lap_prev` is loaded with the synchronised value on entry to RUN, so a level present at release is not counted.
- States:
  - IDLE: `ring_rst`=1, `ring_start`=0. If `run_req`=1, capture `run_len`, clear `lap_count` and `timeout_err`, and go to INIT.
  - INIT: `ring_start`=1, `ring_rst`=1 for RESET_CYCLES cycles, then go to ARM.
  - ARM: `ring_start`=0, `ring_rst`=1 for ARM_CYCLES cycles. Then go to RUN if the captured length is nonzero. If the captured length is 0, pulse `done` and go to IDLE.
  - RUN: `ring_rst`=0, `ring_start`=0.
    - Each lap event increments `lap_count` and clears the watchdog.
    - When `lap_count` reaches the captured length, pulse `done` and go to IDLE.
    - If the watchdog reaches TIMEOUT with no event, set `timeout_err`, pulse `done`, and go to IDLE.
- `abort` in INIT, ARM or RUN goes to IDLE on the next edge with no `done` pulse; `lap_count` holds its value. `abort` in IDLE has no effect.
- `run_req` outside IDLE is ignored; requests are not queued.
- Simultaneous events:
  - `abort` has priority over completion and timeout in the same cycle.
  - A lap event in the same cycle that the watchdog would expire counts as progress; no timeout occurs.
  - `lap_count` saturates at the captured length and never wraps.
- `rst` asserted mid-run forces all reset values on the next edge, so the ring returns to `ring_rst`=1 immediately.

## Timing
- `run_req` sampled high at edge E: `busy`=1, `ring_start`=1, `ring_rst`=1 from E.
- `ring_start` falls at E+RESET_CYCLES.
- `ring_rst` falls at E+RESET_CYCLES+ARM_CYCLES.
- A `lap_in` transition updates `lap_count` at the 3rd rising `clk` edge after it: 2 synchroniser stages plus 1 counter register.
- `done` is high for exactly the cycle in which state returns to IDLE; `busy`=0 and `ring_rst`=1 in that same cycle.
- Minimum period of `lap_in` transitions for guaranteed counting: 2 `clk` periods.
- `occupancy` lags `f_in` by 3 cycles.

## Test plan
- Nominal run: `run_len`=4, `lap_in` toggles every 10 cycles after release. Required: `ring_start`/`ring_rst` sequence 1/1 for 2 cycles, then 0/1 for 2 cycles, then 0/0; `lap_count` steps 1,2,3,4; `done` pulses once; `timeout_err`=0.
- Zero length: `run_len`=0. Required: INIT then ARM (4 cycles), `done` pulse, RUN never entered, `ring_rst` never 0.
- Stall: `run_len`=8, `lap_in` toggles twice then freezes. Required: `lap_count`=2, `timeout_err`=1 and `done` exactly 255 cycles after the last counted event, `ring_rst`=1.
- Abort mid-RUN after 3 events. Required: IDLE next edge, no `done`, `lap_count`=3, `ring_rst`=1. Also `abort` and the final event in the same cycle: no `done`.
- Interference: `run_req` pulsed during RUN is ignored. Then `rst` for 1 cycle mid-RUN: all outputs at reset values next edge. A fresh `run_req` then clears `timeout_err` left from a prior stall.
- Occupancy: drive `f_in`=5'b10110. Required: `occupancy`=3 after 3 cycles; `lap_in` high at release is not counted.

Source files
------------

// File: rtl/q_ring_sequencer.sv
// q_ring_sequencer: runs the reset/start initialisation of a self-timed
// q_stage ring, releases it, counts two-phase lap events seen at the ring's
// observation point, and returns the ring to reset on completion, stall or abort.
//
// Request semantics: run_req is a level sampled only while busy=0 (IDLE).
// The cycle it is seen high it is accepted and busy rises on that same edge.
// While busy=1 run_req is ignored and nothing is queued. done marks the end
// of every run that was not aborted or reset.
module q_ring_sequencer #(
    parameter int NSTAGES      = 5,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int ARM_CYCLES   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run_req,
    input  logic [CNT_W-1:0]                 run_len,
    input  logic                             abort,
    input  logic                             lap_in,
    input  logic [NSTAGES-1:0]               f_in,
    output logic                             ring_start,
    output logic                             ring_rst,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err,
    output logic [CNT_W-1:0]                 lap_count,
    output logic [$clog2(NSTAGES+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(NSTAGES + 1);
    localparam int MAXPH = (RESET_CYCLES > ARM_CYCLES) ? RESET_CYCLES : ARM_CYCLES;
    localparam int PH_W  = $clog2(MAXPH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, INIT, ARM, RUN} state_t;

    state_t             state;
    logic               lap_s1, lap_s2, lap_prev;
    logic [NSTAGES-1:0] f_s1, f_s2;
    logic [OCC_W-1:0]   occ_next;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   lap_next;
    logic [PH_W-1:0]    ph_cnt;
    logic [WD_W-1:0]    wd;
    logic               lap_event;

    // Any change of the synchronised lap level is one event (two-phase signalling).
    // lap_prev always tracks the synchronised level, so a level already present
    // when the ring is released never looks like an edge.
    assign lap_event = (lap_s2 != lap_prev);
    assign lap_next  = lap_count + CNT_W'(1);

    // Popcount of the synchronised stage flags.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            occ_next = occ_next + OCC_W'(f_s2[i]);
        end
    end

    // Two-flop synchronisers for the asynchronous ring signals, edge history and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_s1    <= 1'b0;
            lap_s2    <= 1'b0;
            lap_prev  <= 1'b0;
            f_s1      <= '0;
            f_s2      <= '0;
            occupancy <= '0;
        end else begin
            lap_s1    <= lap_in;
            lap_s2    <= lap_s1;
            lap_prev  <= lap_s2;
            f_s1      <= f_in;
            f_s2      <= f_s1;
            occupancy <= occ_next;
        end
    end

    // Sequencer FSM with registered ring controls, status and lap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ring_rst    <= 1'b1;
            ring_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            lap_count   <= '0;
            len_q       <= '0;
            ph_cnt      <= '0;
            wd          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_req) begin
                        len_q       <= run_len;
                        lap_count   <= '0;
                        timeout_err <= 1'b0;
                        ph_cnt      <= '0;
                        state       <= INIT;
                        ring_start  <= 1'b1;
                        ring_rst    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                INIT: begin
                    if (abort) begin
                        state      <= IDLE;
                        ring_start <= 1'b0;
                        ring_rst   <= 1'b1;
                        busy       <= 1'b0;
                    end else if (ph_cnt == PH_W'(RESET_CYCLES - 1)) begin
                        ph_cnt     <= '0;
                        state      <= ARM;
                        ring_start <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ARM: begin
                    if (abort) begin
                        state    <= IDLE;
                        ring_rst <= 1'b1;
                        busy     <= 1'b0;
                    end else if (ph_cnt == PH_W'(ARM_CYCLES - 1)) begin
                        ph_cnt <= '0;
                        if (len_q == '0) begin
                            // Nothing to count: finish without ever releasing the ring.
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= RUN;
                            ring_rst <= 1'b0;
                            wd       <= '0;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Abort wins over completion and timeout; the count is frozen.
                        state    <= IDLE;
                        ring_rst <= 1'b1;
                        busy     <= 1'b0;
                    end else if (lap_event) begin
                        // An event always counts as progress, even on the watchdog's last cycle.
                        wd <= '0;
                        if (lap_count != len_q) begin
                            lap_count <= lap_next;
                        end
                        if (lap_next == len_q || lap_count == len_q) begin
                            state    <= IDLE;
                            ring_rst <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        ring_rst    <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    ring_rst   <= 1'b1;
                    ring_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_ring_sequencer.sv
// Bench for q_ring_sequencer: table of single-cycle control vectors, hand
// sequences for abort/reset/occupancy corners, and randomized runs checked
// against an edge-arithmetic model of when each lap is counted and when the
// run must end.
module tb_q_ring_sequencer;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req;
  logic [15:0] run_len;
  logic        abort;
  logic        lap_in;
  logic [4:0]  f_in;
  logic        ring_start, ring_rst, busy, done, timeout_err;
  logic [15:0] lap_count;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tog_q[$];
  logic [2:0] exp_q[$];

  typedef struct {
    logic        req;
    logic [15:0] len;
    logic        abt;
    logic        e_start;
    logic        e_rst;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[20];

  q_ring_sequencer dut (
    .clk(clk), .rst(rst), .run_req(run_req), .run_len(run_len), .abort(abort),
    .lap_in(lap_in), .f_in(f_in), .ring_start(ring_start), .ring_rst(ring_rst),
    .busy(busy), .done(done), .timeout_err(timeout_err), .lap_count(lap_count),
    .occupancy(occupancy)
  );

  // clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Apply any lap toggle scheduled for after this edge, then advance one edge.
  task automatic tick();
    if (tog_q.size() > 0 && tog_q[0] == cyc) begin
      lap_in = ~lap_in;
      void'(tog_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic req, input int len, input logic abt,
                      input logic s, input logic r, input logic b, input logic d);
    vecs[i].req = req; vecs[i].len = 16'(len); vecs[i].abt = abt;
    vecs[i].e_start = s; vecs[i].e_rst = r; vecs[i].e_busy = b; vecs[i].e_done = d;
  endtask

  task automatic start_run(input int len, output int e);
    run_req = 1'b1;
    run_len = 16'(len);
    tick();
    e = cyc;
    run_req = 1'b0;
    check("accept_timeout_err_clear", timeout_err, 0);
  endtask

  // One full run. Model: a toggle driven after edge t is counted at edge t+3;
  // the ring is released at accept+4; the run ends at the L-th count, or
  // TIMEOUT edges after the last count (or release) if the laps stop short.
  task automatic do_run(input int L, input int K, input int gap);
    int e, r, d, t, c;
    int sched[$];
    start_run(L, e);
    r = e + 4;
    t = r;
    for (int i = 0; i < K; i++) begin
      t += (gap > 0) ? gap : $urandom_range(2, 20);
      sched.push_back(t);
      tog_q.push_back(t);
    end
    if (L == 0) d = e + 4;
    else if (K >= L) d = sched[L-1] + 3;
    else d = ((K > 0) ? sched[K-1] + 3 : r) + TIMEOUT;
    while (1) begin
      c = 0;
      foreach (sched[i]) if (sched[i] + 3 <= cyc) c++;
      if (c > L) c = L;
      check("lap_count", lap_count, c);
      check("done", done, (cyc == d) ? 1 : 0);
      check("busy", busy, (cyc < d) ? 1 : 0);
      check("ring_rst", ring_rst, (cyc >= r && cyc < d) ? 0 : 1);
      check("ring_start", ring_start, (cyc < e + 2) ? 1 : 0);
      check("timeout_err", timeout_err, (K < L && cyc >= d) ? 1 : 0);
      if (cyc >= d) break;
      tick();
    end
    tog_q.delete();
    tick();
    check("done_single_pulse", done, 0);
    check("end_lap_count", lap_count, (K < L) ? K : L);
  endtask

  initial begin
    int e, r;
    rst = 1'b1; run_req = 1'b0; run_len = '0; abort = 1'b0; lap_in = 1'b0; f_in = '0;
    tick(); tick();
    check("rst_ring_rst", ring_rst, 1);
    check("rst_ring_start", ring_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_lap_count", lap_count, 0);
    check("rst_occupancy", occupancy, 0);
    rst = 1'b0;
    tick();

    // control vectors: zero length, abort in IDLE/INIT/ARM, run_req ignored while busy
    setv(0, 1, 0, 0, 1, 1, 1, 0);  setv(1, 0, 0, 0, 1, 1, 1, 0);
    setv(2, 0, 0, 0, 0, 1, 1, 0);  setv(3, 0, 0, 0, 0, 1, 1, 0);
    setv(4, 0, 0, 0, 0, 1, 0, 1);  setv(5, 0, 0, 0, 0, 1, 0, 0);
    setv(6, 0, 0, 1, 0, 1, 0, 0);  setv(7, 1, 5, 0, 1, 1, 1, 0);
    setv(8, 0, 0, 1, 0, 1, 0, 0);  setv(9, 1, 5, 0, 1, 1, 1, 0);
    setv(10, 0, 0, 0, 1, 1, 1, 0); setv(11, 0, 0, 0, 0, 1, 1, 0);
    setv(12, 0, 0, 1, 0, 1, 0, 0); setv(13, 1, 7, 0, 1, 1, 1, 0);
    setv(14, 1, 7, 0, 1, 1, 1, 0); setv(15, 1, 7, 0, 0, 1, 1, 0);
    setv(16, 1, 7, 0, 0, 1, 1, 0); setv(17, 1, 7, 0, 0, 0, 1, 0);
    setv(18, 1, 7, 0, 0, 0, 1, 0); setv(19, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run_req = vecs[i].req; run_len = vecs[i].len; abort = vecs[i].abt;
      tick();
      check($sformatf("vec%0d_ring_start", i), ring_start, vecs[i].e_start);
      check($sformatf("vec%0d_ring_rst", i), ring_rst, vecs[i].e_rst);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      check($sformatf("vec%0d_lap_count", i), lap_count, 0);
    end
    run_req = 1'b0; abort = 1'b0;
    tick();

    // nominal run, then stall, then a fresh request clears timeout_err
    do_run(4, 4, 10);
    do_run(8, 2, 10);
    do_run(3, 3, 2);

    // lap_in already high at release is not counted
    lap_in = 1'b1;
    do_run(2, 2, 7);

    // abort in RUN after three events
    start_run(6, e);
    r = e + 4;
    tog_q.push_back(r + 2); tog_q.push_back(r + 6); tog_q.push_back(r + 10);
    while (cyc < r + 13) tick();
    check("abort_pre_count", lap_count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_lap_count", lap_count, 3);
    check("abort_ring_rst", ring_rst, 1);
    tick();
    check("abort_done_after", done, 0);

    // abort in the same cycle as the final event
    start_run(2, e);
    r = e + 4;
    tog_q.push_back(r + 2); tog_q.push_back(r + 6);
    while (cyc < r + 8) tick();
    check("abort_final_pre_count", lap_count, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_final_done", done, 0);
    check("abort_final_busy", busy, 0);
    check("abort_final_lap_count", lap_count, 1);
    check("abort_final_ring_rst", ring_rst, 1);
    tick();
    check("abort_final_done_after", done, 0);
    tog_q.delete();

    // synchronous reset mid-RUN
    f_in = 5'b10110;
    start_run(5, e);
    r = e + 4;
    tog_q.push_back(r + 2);
    while (cyc < r + 6) tick();
    check("midrst_pre_count", lap_count, 1);
    check("midrst_pre_occ", occupancy, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ring_rst", ring_rst, 1);
    check("midrst_ring_start", ring_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_lap_count", lap_count, 0);
    check("midrst_occupancy", occupancy, 0);
    tog_q.delete();

    // occupancy lag of three edges
    f_in = '0;
    repeat (4) tick();
    f_in = 5'b10110;
    tick(); tick();
    check("occ_lag2", occupancy, 0);
    tick();
    check("occ_lag3", occupancy, 3);

    // random f_in every cycle against a popcount queue
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      f_in = 5'($urandom_range(0, 31));
      exp_q.push_back(3'($countones(f_in)));
      tick();
      if (exp_q.size() == 3) check("occ_random", occupancy, exp_q.pop_front());
    end

    // randomized runs, some completing and some stalling
    for (int i = 0; i < 6; i++) begin
      int L, K;
      L = $urandom_range(1, 6);
      K = $urandom_range(0, L);
      do_run(L, K, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
